// File: rtl/serv_irq_sched.sv
// Machine interrupt scheduler: pending/enable gating, fixed-priority arbitration and a
// bit-serial mcause stream, LSB first. Define SERV_IRQ_SW_EN to add the MSIP source.
module serv_irq_sched #(
    parameter int unsigned W           = 1,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_mtip,
    input  logic         i_meip,
`ifdef SERV_IRQ_SW_EN
    input  logic         i_msip,
`endif
    input  logic         i_mstatus_mie,
    input  logic [2:0]   i_mie,
    input  logic         i_irq_ack,
    input  logic         i_cnt_en,
    output logic         o_irq_req,
    output logic [W-1:0] o_mcause_q,
    output logic         o_busy,
    output logic [2:0]   o_mip
);

    localparam int unsigned      CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(32 - W);
    localparam logic [3:0]       CODE_MEI = 4'd11;
    localparam logic [3:0]       CODE_MTI = 4'd7;
`ifdef SERV_IRQ_SW_EN
    localparam logic [3:0]       CODE_MSI = 4'd3;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [3:0]             code_q;
    logic                   req_q;
    logic                   busy_q;
    logic [W-1:0]           data_q;
    logic [SYNC_STAGES-1:0] meip_sync_q;
    logic                   mtip_prev_q;
    logic                   mtip_q;

    logic                   msip;
    logic [2:0]             mip;
    logic [2:0]             pend;
    logic                   eligible;
    logic                   mtip_set;
    logic                   mtip_clr;
    logic [3:0]             win_code;
    logic [31:0]            cause;
    logic [CNT_W-1:0]       cnt_nxt;

`ifdef SERV_IRQ_SW_EN
    assign msip = i_msip;
`else
    assign msip = 1'b0;
`endif

    assign mip      = {meip_sync_q[SYNC_STAGES-1], mtip_q, msip};
    assign pend     = mip & i_mie;
    assign eligible = i_mstatus_mie & (|pend);
    assign mtip_set = i_mtip & ~mtip_prev_q;
    assign mtip_clr = (state_q == REQ) & i_irq_ack & (code_q == CODE_MTI);
    assign cause    = {1'b1, 27'b0, code_q};
    assign cnt_nxt  = cnt_q + CNT_STEP;

    // Fixed priority: external first, then software (if present), then timer.
    always_comb begin
        win_code = 4'd0;
        if (pend[2]) begin
            win_code = CODE_MEI;
`ifdef SERV_IRQ_SW_EN
        end else if (pend[0]) begin
            win_code = CODE_MSI;
`endif
        end else if (pend[1]) begin
            win_code = CODE_MTI;
        end
    end

    // Pending sources: MEIP synchroniser, MTIP edge capture (a new edge beats a clear).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meip_sync_q <= '0;
            mtip_prev_q <= 1'b0;
            mtip_q      <= 1'b0;
        end else begin
            meip_sync_q <= {meip_sync_q[SYNC_STAGES-2:0], i_meip};
            mtip_prev_q <= i_mtip;
            if (mtip_set) begin
                mtip_q <= 1'b1;
            end else if (mtip_clr) begin
                mtip_q <= 1'b0;
            end
        end
    end

    // Request/stream FSM; data_q is loaded with the beat that the next state will present.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            data_q <= '0;
            case (state_q)
                IDLE: begin
                    if (eligible) begin
                        state_q <= REQ;
                        code_q  <= win_code;
                        req_q   <= 1'b1;
                    end
                end
                REQ: begin
                    if (i_irq_ack) begin
                        state_q <= SHIFT;
                        req_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        data_q  <= W'(cause);
                    end else if (!eligible) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (i_cnt_en) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q  <= cnt_nxt;
                            data_q <= W'(cause >> cnt_nxt);
                        end
                    end else begin
                        data_q <= W'(cause >> cnt_q);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_irq_req  = req_q;
    assign o_busy     = busy_q;
    assign o_mcause_q = data_q;
    assign o_mip      = mip;

endmodule

// File: tb/tb_serv_irq_sched.sv
// Bench for serv_irq_sched: a W=1 instance driven from a vector table plus corner
// sequences, and a W=4 instance for the nibble stream; cause beats checked via a queue.
module tb_serv_irq_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst4, mtip, meip, g, ack, cnt_en, cnt_en4;
    logic [2:0] mie;
`ifdef SERV_IRQ_SW_EN
    logic       msip;
`endif
    logic       req1, busy1, req4, busy4;
    logic [0:0] mc1;
    logic [3:0] mc4;
    logic [2:0] mip1, mip4;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [3:0] exp_q[$];

    serv_irq_sched #(.W(1), .SYNC_STAGES(2)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_mtip(mtip), .i_meip(meip),
`ifdef SERV_IRQ_SW_EN
        .i_msip(msip),
`endif
        .i_mstatus_mie(g), .i_mie(mie), .i_irq_ack(ack), .i_cnt_en(cnt_en),
        .o_irq_req(req1), .o_mcause_q(mc1), .o_busy(busy1), .o_mip(mip1)
    );

    serv_irq_sched #(.W(4), .SYNC_STAGES(2)) u_dut4 (
        .i_clk(clk), .i_rst(rst4), .i_mtip(mtip), .i_meip(meip),
`ifdef SERV_IRQ_SW_EN
        .i_msip(msip),
`endif
        .i_mstatus_mie(g), .i_mie(mie), .i_irq_ack(ack), .i_cnt_en(cnt_en4),
        .o_irq_req(req4), .o_mcause_q(mc4), .o_busy(busy4), .o_mip(mip4)
    );

    typedef struct packed {
        logic        rst, mtip, meip, g;
        logic [2:0]  mie;
        logic        ack;
        logic        req, busy;
        logic [2:0]  mip;
        logic [31:0] strm;
    } vec_t;

    vec_t tbl[22];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] cur_beat(input bit wide);
        return wide ? mc4 : {3'b000, mc1};
    endfunction

    // Pushes every expected beat, then pops one per strobe; random strobe gaps must hold data.
    task automatic run_stream(input logic [31:0] cause, input bit wide);
        int nb = wide ? 8 : 32;
        logic [3:0] beat;
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            if (wide) exp_q.push_back(4'(cause >> (4 * b)));
            else      exp_q.push_back(4'((cause >> b) & 32'd1));
        end
        ack = 1'b0;
        for (int b = 0; b < nb; b++) begin
            if ($urandom_range(0, 3) == 0) begin
                tick();
                chk($sformatf("gap_hold_b%0d", b), 32'(cur_beat(wide)), 32'(exp_q[0]));
            end
            beat = exp_q.pop_front();
            chk($sformatf("beat%0d_w%0d", b, wide ? 4 : 1), 32'(cur_beat(wide)), 32'(beat));
            if (wide) cnt_en4 = 1'b1;
            else      cnt_en  = 1'b1;
            tick();
            cnt_en  = 1'b0;
            cnt_en4 = 1'b0;
        end
        chk("busy_after_stream", 32'(wide ? busy4 : busy1), 32'd0);
        chk("data_after_stream", 32'(cur_beat(wide)), 32'd0);
    endtask

    initial begin
        logic [31:0] cause4;
        //        rst mtip meip g  mie    ack   req busy mip     stream
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 3'b000, 32'h80000007};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 3'b010, 32'h0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 3'b010, 32'h80000007};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b010, 1'b1, 1'b0, 1'b1, 3'b000, 32'h80000007};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 3'b110, 32'h0};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 3'b110, 32'h0};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b1, 3'b110, 32'h8000000B};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 3'b010, 32'h0};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 1'b1, 3'b000, 32'h80000007};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0};

        rst = 1'b1; rst4 = 1'b1; mtip = 1'b0; meip = 1'b0; g = 1'b0;
        mie = 3'b000; ack = 1'b0; cnt_en = 1'b0; cnt_en4 = 1'b0;
`ifdef SERV_IRQ_SW_EN
        msip = 1'b0;
`endif
        tick();
        tick();
        chk("w4_rst_req",  32'(req4),  32'd0);
        chk("w4_rst_busy", 32'(busy4), 32'd0);
        chk("w4_rst_data", 32'(mc4),   32'd0);
        chk("w4_rst_mip",  32'(mip4),  32'd0);

        // Arbitration, withdrawal, set-beats-clear and re-request rows on the W=1 instance.
        for (int i = 0; i < 22; i++) begin
            rst = tbl[i].rst; mtip = tbl[i].mtip; meip = tbl[i].meip;
            g = tbl[i].g; mie = tbl[i].mie; ack = tbl[i].ack;
            tick();
            chk($sformatf("v%0d_req", i),  32'(req1),  32'(tbl[i].req));
            chk($sformatf("v%0d_busy", i), 32'(busy1), 32'(tbl[i].busy));
            chk($sformatf("v%0d_mip", i),  32'(mip1),  32'(tbl[i].mip));
            if (!tbl[i].busy) chk($sformatf("v%0d_data", i), 32'(mc1), 32'd0);
            if (tbl[i].strm != 32'h0) run_stream(tbl[i].strm, 1'b0);
        end

        // Reset mid-stream after 10 beats, then a fresh request streams from bit 0.
        rst = 1'b1;
        tick();
        rst = 1'b0; mie = 3'b010; g = 1'b1; mtip = 1'b1;
        tick();
        tick();
        chk("mid_rst_req", 32'(req1), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("mid_rst_busy", 32'(busy1), 32'd1);
        for (int b = 0; b < 10; b++) begin
            chk($sformatf("pre_rst_beat%0d", b), 32'(mc1), (32'h80000007 >> b) & 32'd1);
            cnt_en = 1'b1;
            tick();
            cnt_en = 1'b0;
        end
        rst = 1'b1;
        tick();
        chk("abort_req",  32'(req1),  32'd0);
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_data", 32'(mc1),   32'd0);
        chk("abort_mip",  32'(mip1),  32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("restart_req", 32'(req1), 32'd1);
        ack = 1'b1;
        tick();
        run_stream(32'h80000007, 1'b0);
        mtip = 1'b0; g = 1'b0; mie = 3'b000;
        tick();

        // W=4 nibble stream on the second instance.
        rst = 1'b1; rst4 = 1'b0;
        g = 1'b1;
`ifdef SERV_IRQ_SW_EN
        msip = 1'b1; mie = 3'b001; cause4 = 32'h80000003;
        tick();
`else
        mtip = 1'b1; mie = 3'b010; cause4 = 32'h80000007;
        tick();
        tick();
`endif
        chk("w4_req", 32'(req4), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
`ifdef SERV_IRQ_SW_EN
        msip = 1'b0;
`endif
        chk("w4_busy", 32'(busy4), 32'd1);
        run_stream(cause4, 1'b1);
        chk("w4_req_after", 32'(req4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
